sr_latch_driver: RTL and testbench

Command-side driver for an SR storage flip-flop. It takes set/reset requests over a valid/ready handshake and issues a timed s or r pulse. It never asserts s and r together. After the pulse it waits a guard interval, then reads back the flip-flop's q/q1 outputs to confirm the new state, retrying a bounded number of times. It sits between control logic and any srff-style element that needs guaranteed-exclusive, verified drive.

---
 rtl/sr_latch_driver.sv | 175 +++++++++++++++++
 tb/tb_sr_latch_driver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Command-side driver for an SR storage flip-flop. A set/reset request is
// accepted over a valid/ready handshake, a timed s or r pulse is issued, a
// guard interval of s=r=0 follows, and the flip-flop's q/q1 feedback is then
// checked. On mismatch the pulse is repeated up to MAX_RETRY more times.
// s and r come from one registered target bit and are never high together.
//
// Parameters:
//   PULSE_W   : cycles s or r is held high per attempt        (1..255)
//   GUARD     : dead cycles after a pulse before the check     (1..255)
//   MAX_RETRY : extra attempts after the first failed check    (0..15)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   request present
//   cmd_set    in   target level: 1 = set (q=1,q1=0), 0 = reset (q=0,q1=1)
//   cmd_ready  out  high in IDLE
//   fb_q       in   q from the driven flip-flop
//   fb_q1      in   q1 from the driven flip-flop
//   s          out  set drive
//   r          out  reset drive
//   busy       out  high whenever the FSM is not in IDLE
//   done       out  one-cycle pulse: target confirmed
//   err        out  one-cycle pulse: retries exhausted
//   state_q    out  last confirmed level (reset value 1)
//   attempts   out  pulses issued for the current/last command
// -----------------------------------------------------------------------------
module sr_latch_driver #(
   parameter int unsigned PULSE_W   = 1,
   parameter int unsigned GUARD     = 2,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic       cmd_set,
   output logic       cmd_ready,
   input  logic       fb_q,
   input  logic       fb_q1,
   output logic       s,
   output logic       r,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       state_q,
   output logic [3:0] attempts
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GUARD = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   // Counters count down to zero, so they are loaded with length-1.
   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_W - 1);
   localparam logic [7:0] GUARD_LOAD = 8'(GUARD - 1);
   localparam logic [4:0] RETRY_LIM  = 5'(MAX_RETRY);

   state_t      r_state;
   logic        r_target;
   logic [7:0]  r_cnt;
   // Internal try count is 5 bits: MAX_RETRY=15 allows 16 attempts, which
   // does not fit the 4-bit attempts output (that one saturates at 15).
   logic [4:0]  r_tries;

   logic        w_transfer;
   logic        w_match;
   logic        w_can_retry;

   // Feedback is a confirmation only when q and q1 are complementary and q
   // equals the target; q==q1 (invalid SR state) is always a mismatch.
   function automatic logic fb_match(input logic q, input logic q1, input logic tgt);
      return (q == tgt) && (q1 == ~tgt);
   endfunction

   assign w_transfer  = cmd_valid & cmd_ready;
   assign w_match     = fb_match(fb_q, fb_q1, r_target);
   assign w_can_retry = (r_tries <= RETRY_LIM);

   // Control FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_target  <= 1'b1;
         r_cnt     <= 8'd0;
         r_tries   <= 5'd0;
         s         <= 1'b0;
         r         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cmd_ready <= 1'b1;
         state_q   <= 1'b1;
         attempts  <= 4'd0;
      end else begin
         // Status pulses last exactly one cycle.
         done <= 1'b0;
         err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_transfer) begin
                  r_target  <= cmd_set;
                  r_tries   <= 5'd1;
                  attempts  <= 4'd1;
                  r_cnt     <= PULSE_LOAD;
                  s         <= cmd_set;
                  r         <= ~cmd_set;
                  busy      <= 1'b1;
                  cmd_ready <= 1'b0;
                  r_state   <= ST_PULSE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_PULSE: begin
               if (r_cnt == 8'd0) begin
                  s       <= 1'b0;
                  r       <= 1'b0;
                  r_cnt   <= GUARD_LOAD;
                  r_state <= ST_GUARD;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end

            ST_GUARD: begin
               if (r_cnt == 8'd0) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end

            ST_CHECK: begin
               if (w_match) begin
                  done      <= 1'b1;
                  state_q   <= r_target;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  r_state   <= ST_IDLE;
               end else if (w_can_retry) begin
                  // Re-enter PULSE with the drive already asserted so the
                  // retry period is exactly PULSE_W+GUARD+1 cycles.
                  r_tries  <= r_tries + 5'd1;
                  attempts <= (attempts == 4'hF) ? 4'hF : attempts + 4'd1;
                  r_cnt    <= PULSE_LOAD;
                  s        <= r_target;
                  r        <= ~r_target;
                  r_state  <= ST_PULSE;
               end else begin
                  err       <= 1'b1;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end

            default: begin
               s         <= 1'b0;
               r         <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Directed bench for sr_latch_driver. Two instances: u_def with default
// parameters and u_p3 with PULSE_W=3, GUARD=1. Each instance is fed by a
// behavioural SR flip-flop; u_def's feedback can be overridden to model
// stuck or late-settling hardware. Cycle c means the interval after the
// (c-1)th rising edge counted from the transfer edge (cycle 0).
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---- default-parameter instance ----
   logic       d_rst, d_valid, d_set, d_fbq, d_fbq1;
   logic       d_ready, d_s, d_r, d_busy, d_done, d_err, d_stq;
   logic [3:0] d_att;
   logic       dq, dq1;
   logic       force_fb, f_q, f_q1;

   // ---- PULSE_W=3, GUARD=1 instance ----
   logic       p_rst, p_valid, p_set;
   logic       p_ready, p_s, p_r, p_busy, p_done, p_err, p_stq;
   logic [3:0] p_att;
   logic       pq, pq1;

   sr_latch_driver u_def (
      .clk(clk), .rst(d_rst), .cmd_valid(d_valid), .cmd_set(d_set),
      .cmd_ready(d_ready), .fb_q(d_fbq), .fb_q1(d_fbq1),
      .s(d_s), .r(d_r), .busy(d_busy), .done(d_done), .err(d_err),
      .state_q(d_stq), .attempts(d_att)
   );

   sr_latch_driver #(.PULSE_W(3), .GUARD(1), .MAX_RETRY(3)) u_p3 (
      .clk(clk), .rst(p_rst), .cmd_valid(p_valid), .cmd_set(p_set),
      .cmd_ready(p_ready), .fb_q(pq), .fb_q1(pq1),
      .s(p_s), .r(p_r), .busy(p_busy), .done(p_done), .err(p_err),
      .state_q(p_stq), .attempts(p_att)
   );

   // Behavioural SR flip-flops (q=1 at reset).
   always @(posedge clk) begin
      if (d_rst) begin dq <= 1'b1; dq1 <= 1'b0; end
      else if (d_s) begin dq <= 1'b1; dq1 <= 1'b0; end
      else if (d_r) begin dq <= 1'b0; dq1 <= 1'b1; end
   end
   always @(posedge clk) begin
      if (p_rst) begin pq <= 1'b1; pq1 <= 1'b0; end
      else if (p_s) begin pq <= 1'b1; pq1 <= 1'b0; end
      else if (p_r) begin pq <= 1'b0; pq1 <= 1'b1; end
   end
   assign d_fbq  = force_fb ? f_q  : dq;
   assign d_fbq1 = force_fb ? f_q1 : dq1;

   // Exclusivity monitor, sampled mid-cycle on both instances.
   always @(negedge clk) begin
      checks++;
      if ((d_s & d_r) !== 1'b0 || (p_s & p_r) !== 1'b0) begin
         errors++;
         $display("FAIL excl t=%0t d_s=%b d_r=%b p_s=%b p_r=%b required no s&r", $time, d_s, d_r, p_s, p_r);
      end
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      d_rst = 1'b1; p_rst = 1'b1;
      repeat (3) next_cycle();
      d_rst = 1'b0; p_rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         checks++;
         if ({d_s, d_r, d_busy, d_done, d_err, d_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_idle_d c=%0d got s,r,busy,done,err,ready=%b required 000001", c, {d_s, d_r, d_busy, d_done, d_err, d_ready});
         end
         checks++;
         if ({p_s, p_r, p_busy, p_done, p_err, p_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_idle_p c=%0d got s,r,busy,done,err,ready=%b required 000001", c, {p_s, p_r, p_busy, p_done, p_err, p_ready});
         end
         next_cycle();
      end
      checks++;
      if (d_stq !== 1'b1 || d_att !== 4'd0) begin
         errors++;
         $display("FAIL reset_regs_d got state_q=%b attempts=%0d required 1 0", d_stq, d_att);
      end
      checks++;
      if (p_stq !== 1'b1 || p_att !== 4'd0) begin
         errors++;
         $display("FAIL reset_regs_p got state_q=%b attempts=%0d required 1 0", p_stq, p_att);
      end
   endtask

   task automatic test_set_default;
      d_set = 1'b1; d_valid = 1'b1;
      next_cycle();
      d_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if ({d_s, d_r, d_done, d_err} !== {(c == 1), 1'b0, (c == 5), 1'b0}) begin
            errors++;
            $display("FAIL set_def c=%0d got s,r,done,err=%b required %b", c, {d_s, d_r, d_done, d_err}, {(c == 1), 1'b0, (c == 5), 1'b0});
         end
         checks++;
         if (d_ready !== (c >= 5)) begin
            errors++;
            $display("FAIL set_def_ready c=%0d got %b required %b", c, d_ready, (c >= 5));
         end
         next_cycle();
      end
      checks++;
      if (d_stq !== 1'b1 || d_att !== 4'd1) begin
         errors++;
         $display("FAIL set_def_regs got state_q=%b attempts=%0d required 1 1", d_stq, d_att);
      end
   endtask

   task automatic test_reset_cmd_p3;
      p_set = 1'b0; p_valid = 1'b1;
      next_cycle();
      p_valid = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         checks++;
         if ({p_s, p_r, p_done, p_err} !== {1'b0, (c <= 3), (c == 6), 1'b0}) begin
            errors++;
            $display("FAIL rst_p3 c=%0d got s,r,done,err=%b required %b", c, {p_s, p_r, p_done, p_err}, {1'b0, (c <= 3), (c == 6), 1'b0});
         end
         checks++;
         if (p_busy !== (c <= 5)) begin
            errors++;
            $display("FAIL rst_p3_busy c=%0d got %b required %b", c, p_busy, (c <= 5));
         end
         next_cycle();
      end
      checks++;
      if (p_stq !== 1'b0 || p_att !== 4'd1) begin
         errors++;
         $display("FAIL rst_p3_regs got state_q=%b attempts=%0d required 0 1", p_stq, p_att);
      end
   endtask

   task automatic test_stuck;
      force_fb = 1'b1; f_q = 1'b1; f_q1 = 1'b1;
      d_set = 1'b0; d_valid = 1'b1;
      next_cycle();
      d_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         checks++;
         if ({d_s, d_r, d_done, d_err} !== {1'b0, (c == 1 || c == 5 || c == 9 || c == 13), 1'b0, (c == 17)}) begin
            errors++;
            $display("FAIL stuck c=%0d got s,r,done,err=%b required %b", c, {d_s, d_r, d_done, d_err},
                     {1'b0, (c == 1 || c == 5 || c == 9 || c == 13), 1'b0, (c == 17)});
         end
         next_cycle();
      end
      checks++;
      if (d_stq !== 1'b1 || d_att !== 4'd4) begin
         errors++;
         $display("FAIL stuck_regs got state_q=%b attempts=%0d required 1 4", d_stq, d_att);
      end
      force_fb = 1'b0;
   endtask

   task automatic test_late_success;
      force_fb = 1'b1; f_q = 1'b1; f_q1 = 1'b0;
      d_set = 1'b0; d_valid = 1'b1;
      next_cycle();
      d_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         checks++;
         if ({d_s, d_r, d_done, d_err} !== {1'b0, (c == 1 || c == 5), (c == 9), 1'b0}) begin
            errors++;
            $display("FAIL late c=%0d got s,r,done,err=%b required %b", c, {d_s, d_r, d_done, d_err}, {1'b0, (c == 1 || c == 5), (c == 9), 1'b0});
         end
         // Feedback settles between the first check (cycle 4) and the second (cycle 8).
         if (c == 6) begin f_q = 1'b0; f_q1 = 1'b1; end
         next_cycle();
      end
      checks++;
      if (d_stq !== 1'b0 || d_att !== 4'd2) begin
         errors++;
         $display("FAIL late_regs got state_q=%b attempts=%0d required 0 2", d_stq, d_att);
      end
      force_fb = 1'b0;
   endtask

   task automatic test_back_to_back;
      d_set = 1'b1; d_valid = 1'b1;
      next_cycle();
      for (int c = 1; c <= 15; c++) begin
         checks++;
         if ({d_s, d_r, d_done} !== {(c == 1 || c == 11), (c == 6), (c == 5 || c == 10 || c == 15)}) begin
            errors++;
            $display("FAIL b2b c=%0d got s,r,done=%b required %b", c, {d_s, d_r, d_done},
                     {(c == 1 || c == 11), (c == 6), (c == 5 || c == 10 || c == 15)});
         end
         if (c == 5)  d_set = 1'b0;
         if (c == 10) d_set = 1'b1;
         if (c == 15) d_valid = 1'b0;
         next_cycle();
      end
      checks++;
      if (d_stq !== 1'b1 || d_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end got state_q=%b busy=%b required 1 0", d_stq, d_busy);
      end
   endtask

   task automatic test_abort;
      d_set = 1'b0; d_valid = 1'b1;
      next_cycle();
      d_valid = 1'b0;
      checks++;
      if (d_r !== 1'b1 || d_busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_start got r=%b busy=%b required 1 1", d_r, d_busy);
      end
      next_cycle();
      d_rst = 1'b1;
      next_cycle();
      d_rst = 1'b0;
      for (int c = 3; c <= 12; c++) begin
         checks++;
         if ({d_s, d_r, d_busy, d_done, d_err, d_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL abort c=%0d got s,r,busy,done,err,ready=%b required 000001", c, {d_s, d_r, d_busy, d_done, d_err, d_ready});
         end
         next_cycle();
      end
      checks++;
      if (d_stq !== 1'b1 || d_att !== 4'd0) begin
         errors++;
         $display("FAIL abort_regs got state_q=%b attempts=%0d required 1 0", d_stq, d_att);
      end
   endtask

   initial begin
      d_rst = 1'b1; d_valid = 1'b0; d_set = 1'b0;
      p_rst = 1'b1; p_valid = 1'b0; p_set = 1'b0;
      force_fb = 1'b0; f_q = 1'b0; f_q1 = 1'b0;
      #1;
      test_reset();
      test_set_default();
      test_reset_cmd_p3();
      test_stuck();
      test_late_success();
      test_back_to_back();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
